// File: rtl/spiker_result_capture.sv
// rtl/spiker_result_capture.sv - assembles spike result frames from beats and commits them atomically to a register bank
module spiker_result_capture #(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int BEAT_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BEAT_WIDTH-1:0]    in_data_i,
  input  logic                     in_valid_i,
  input  logic                     in_last_i,
  output logic                     in_ready_o,
  input  logic                     accum_i,
  input  logic                     ack_i,
  input  logic                     clear_i,
  output logic [N_REG*WIDTH-1:0]   result_o,
  output logic                     new_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic                     frame_err_o,
  output logic [CNT_WIDTH-1:0]     frame_cnt_o
);

  localparam int FRAME_W = N_REG * WIDTH;
  localparam int N_BEATS = FRAME_W / BEAT_WIDTH;
  localparam int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

  if ((FRAME_W % BEAT_WIDTH) != 0 || N_BEATS < 1) begin : g_param_check
    $error("BEAT_WIDTH must evenly divide N_REG*WIDTH");
  end

  typedef enum logic [1:0] {
    FILL,
    DROP,
    COMMIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [FRAME_W-1:0]   shadow;
  logic                 beat_ok;

  // Ready never looks at valid, so the upstream stage cannot form a loop through us.
  assign in_ready_o = !clear_i && (state != COMMIT);
  assign beat_ok    = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= FILL;
      idx         <= '0;
      shadow      <= '0;
      result_o    <= '0;
      new_o       <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
      frame_cnt_o <= '0;
    end else if (clear_i) begin
      state       <= FILL;
      idx         <= '0;
      shadow      <= '0;
      result_o    <= '0;
      new_o       <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (ack_i) new_o <= 1'b0;
      case (state)
        FILL: begin
          if (beat_ok) begin
            shadow[int'(idx)*BEAT_WIDTH +: BEAT_WIDTH] <= in_data_i;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (in_last_i) begin
                state <= COMMIT;
              end else begin
                state       <= DROP;
                frame_err_o <= 1'b1;
              end
            end else if (in_last_i) begin
              idx         <= '0;
              frame_err_o <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DROP: begin
          if (beat_ok && in_last_i) begin
            state <= FILL;
            idx   <= '0;
          end
        end
        COMMIT: begin
          // A commit beats a same-cycle ack: the fresh frame is still unread.
          result_o    <= accum_i ? (result_o | shadow) : shadow;
          frame_cnt_o <= frame_cnt_o + 1'b1;
          new_o       <= 1'b1;
          done_o      <= 1'b1;
          if (new_o && !ack_i) overflow_o <= 1'b1;
          state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_spiker_result_capture.sv
// tb/tb_spiker_result_capture.sv - self-checking bench for spiker_result_capture
module tb_spiker_result_capture;

  localparam int W  = 32;
  localparam int NR = 24;
  localparam int BW = 64;
  localparam int CW = 2;
  localparam int FW = NR * W;
  localparam int NB = FW / BW;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [BW-1:0]   in_data_i;
  logic            in_valid_i;
  logic            in_last_i;
  logic            in_ready_o;
  logic            accum_i;
  logic            ack_i;
  logic            clear_i;
  logic [FW-1:0]   result_o;
  logic            new_o;
  logic            done_o;
  logic            overflow_o;
  logic            frame_err_o;
  logic [CW-1:0]   frame_cnt_o;

  spiker_result_capture #(
    .WIDTH(W), .N_REG(NR), .BEAT_WIDTH(BW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
    .accum_i(accum_i), .ack_i(ack_i), .clear_i(clear_i),
    .result_o(result_o), .new_o(new_o), .done_o(done_o), .overflow_o(overflow_o),
    .frame_err_o(frame_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FW-1:0] bank_m, pat;
  logic [CW-1:0] cnt_m;
  logic          new_m, ovf_m, err_m;
  logic [FW-1:0] exp_q[$];

  typedef struct {
    logic          pre_clear;
    logic [31:0]   word;
    logic          rnd;
    logic          accum;
    logic          ackc;
    logic          ack_after;
    logic          exp_ovf;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest expected bank.
  always @(negedge clk_i) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done_o=1 expected no commit");
      end else begin
        chk("commit_result", result_o, exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] d, input logic last);
    int guard = 0;
    in_data_i  = d;
    in_last_i  = last;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    if (!in_ready_o) chk("ready_timeout", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nb, input int last_at,
                            input logic rnd, input logic accum);
    accum_i = accum;
    for (int k = 0; k < nb; k++) begin
      if (rnd) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        #1;
      end
      send_beat(f[k*BW +: BW], k == last_at);
    end
  endtask

  task automatic commit_frame(input logic [FW-1:0] f, input logic rnd, input logic accum,
                              input logic ackc);
    send_frame(f, NB, NB - 1, rnd, accum);
    bank_m = accum ? (bank_m | f) : f;
    cnt_m  = cnt_m + 1'b1;
    if (new_m && !ackc) ovf_m = 1'b1;
    new_m = 1'b1;
    exp_q.push_back(bank_m);
    ack_i = ackc;
    @(negedge clk_i);
    chk("ready_low_in_commit", in_ready_o, 0);
    chk("done_low_in_commit", done_o, 0);
    @(posedge clk_i);
    #1;
    ack_i = 1'b0;
    chk("ready_back_after_commit", in_ready_o, 1);
    chk("done_pulse", done_o, 1);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    ack_i = 1'b0;
    new_m = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_result"}, result_o, bank_m);
    chk({tag, "_new"}, new_o, new_m);
    chk({tag, "_ovf"}, overflow_o, ovf_m);
    chk({tag, "_err"}, frame_err_o, err_m);
    chk({tag, "_cnt"}, frame_cnt_o, cnt_m);
  endtask

  task automatic model_zero();
    bank_m = '0;
    cnt_m  = '0;
    new_m  = 1'b0;
    ovf_m  = 1'b0;
    err_m  = 1'b0;
  endtask

  task automatic do_clear();
    clear_i    = 1'b1;
    in_valid_i = 1'b1;
    in_last_i  = 1'b1;
    in_data_i  = '1;
    @(negedge clk_i);
    chk("ready_low_in_clear", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    model_zero();
    check_all("clear");
    chk("clear_done", done_o, 0);
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    in_last_i  = 1'b1;
    in_data_i  = '1;
    @(posedge clk_i);
    #1;
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    model_zero();
    check_all("reset");
    chk("reset_done", done_o, 0);
    chk("reset_ready", in_ready_o, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) pat[i*W +: W] = $urandom;

    // pre_clear, word (0 = random pattern), rnd, accum, ackc, ack_after, exp_ovf, exp_cnt
    tbl[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[1] = '{1'b0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    tbl[2] = '{1'b0, 32'h0000_000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
    tbl[3] = '{1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[6] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{1'b0, 32'h0000_00F0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};

    rst_i = 1'b1; in_data_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0;
    accum_i = 1'b0; ack_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_zero();
    check_all("init");
    chk("init_ready", in_ready_o, 1);
    chk("init_done", done_o, 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_clear) do_clear();
      f = (tbl[i].word == 32'h0) ? pat : {NR{tbl[i].word}};
      commit_frame(f, tbl[i].rnd, tbl[i].accum, tbl[i].ackc);
      chk("row_new", new_o, 1);
      chk("row_ovf", overflow_o, tbl[i].exp_ovf);
      chk("row_cnt", frame_cnt_o, tbl[i].exp_cnt);
      check_all("row_model");
      if (tbl[i].ack_after) begin
        do_ack();
        chk("ack_new", new_o, 0);
        chk("ack_keeps_ovf", overflow_o, ovf_m);
      end
    end

    // Short frame, then long frame with a 3-beat tail: both discarded.
    send_frame(~pat, 6, 5, 1'b0, 1'b0);
    err_m = 1'b1;
    check_all("short_frame");
    commit_frame(~pat, 1'b0, 1'b0, 1'b0);
    check_all("after_short");
    send_frame(pat, NB, -1, 1'b0, 1'b0);
    send_frame({NR{32'hDEAD_BEEF}}, 3, 2, 1'b0, 1'b0);
    check_all("long_frame");
    commit_frame({NR{32'h1234_5678}}, 1'b1, 1'b0, 1'b0);
    check_all("after_long");

    // Reset mid-frame discards the partial frame.
    send_frame(pat, 7, -1, 1'b0, 1'b0);
    do_reset();
    commit_frame(pat, 1'b0, 1'b0, 1'b0);
    chk("post_reset_cnt", frame_cnt_o, 2'd1);
    check_all("post_reset");

    // Counter wrap: five commits from zero land on 1.
    do_clear();
    for (int i = 0; i < 5; i++) begin
      commit_frame({NR{32'(i + 1)}}, 1'b0, 1'b0, 1'b0);
      do_ack();
    end
    chk("wrap_cnt", frame_cnt_o, 2'd1);
    check_all("wrap");
    do_clear();

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spiker_result_capture.md
Name: spiker_result_capture

Overview:
Parametrised successor to the spike-result writer. It assembles a spike result frame from a narrow valid/ready beat stream into a shadow buffer, then commits it atomically into a register-visible bank of N_REG words of WIDTH bits. The bank is either overwritten or OR-accumulated. Status flags (new data, overflow, framing error) and a frame counter are provided for the adapter register file. It sits between the spiker core output stream and the hw2reg result registers.

Parameters:
WIDTH, 32, register word width in bits
N_REG, 24, number of result words; frame size FRAME_W = N_REG*WIDTH
BEAT_WIDTH, 64, input beat width; must divide FRAME_W; N_BEATS = FRAME_W/BEAT_WIDTH (elaboration error otherwise)
CNT_WIDTH, 16, committed-frame counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
in_data_i  input  BEAT_WIDTH  spike beat; beat k fills frame bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH]
in_valid_i  input  1  beat valid
in_last_i  input  1  beat is the final beat of the frame
in_ready_o  output  1  beat accepted when in_valid_i && in_ready_o
accum_i  input  1  commit mode: 0 = overwrite, 1 = bank |= shadow
ack_i  input  1  software acknowledge; clears new_o
clear_i  input  1  zero the bank, status and counter; restart fill
result_o  output  FRAME_W  bank contents; word i = result_o[(i+1)*WIDTH-1 -: WIDTH]
new_o  output  1  sticky flag: committed frame not yet acknowledged
done_o  output  1  one-cycle pulse per commit
overflow_o  output  1  sticky: commit occurred while new_o was set
frame_err_o  output  1  sticky: framing error detected
frame_cnt_o  output  CNT_WIDTH  committed-frame count, wraps modulo 2^CNT_WIDTH

Behaviour:
- Synchronous reset (rst_i=1 at posedge) takes priority over all inputs. After reset: state FILL, beat index 0, shadow and result_o all zero, new_o/done_o/overflow_o/frame_err_o = 0, frame_cnt_o = 0, in_ready_o = 1.
- Reset asserted mid-frame discards the partial frame. Any beat presented in the reset cycle is not accepted.
- States:
  - FILL: in_ready_o=1. Each accepted beat is written into the shadow slice at the beat index, and the index increments.
    - Accepted beat at index N_BEATS-1 with in_last_i=1 -> COMMIT, index to 0.
    - Accepted beat with in_last_i=1 at index < N_BEATS-1 (short frame) -> frame_err_o set, index to 0, remain FILL, frame discarded.
    - Accepted beat at index N_BEATS-1 with in_last_i=0 (long frame) -> frame_err_o set, go to DROP.
  - DROP: in_ready_o=1. Beats are accepted and discarded. An accepted beat with in_last_i=1 -> FILL, index 0.
  - COMMIT: lasts exactly one cycle, with in_ready_o=0.
    - result_o <= accum_i ? (result_o | shadow) : shadow.
    - frame_cnt_o increments.
    - new_o <= 1.
    - overflow_o set if new_o was 1 and ack_i=0 in that cycle.
    - Next state FILL.
- Latency: final beat accepted at edge T -> result_o, new_o and frame_cnt_o updated at edge T+1. done_o is high for the cycle following edge T+1. Maximum throughput is one frame per N_BEATS+1 cycles.
- ack_i clears new_o. If ack_i and a commit fall in the same cycle, the commit wins: new_o stays 1 and overflow_o is not set. ack_i does not clear overflow_o or frame_err_o.
- clear_i takes priority over commit, ack and fill, but is below reset. It zeroes result_o, shadow, new_o, overflow_o, frame_err_o and frame_cnt_o, and forces state FILL, index 0. A beat presented in the same cycle is not accepted (in_ready_o=0 while clear_i=1).
- frame_cnt_o wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- All outputs are registered. in_ready_o is combinational from the state and clear_i only, never from in_valid_i.

Test Plan:
- Defaults: reset, then send 12 beats with distinct patterns, last on beat 11 -> result_o word 0 = beat0[31:0] and word 1 = beat0[63:32]; new_o=1; frame_cnt_o=1; done_o pulses once, 2 cycles after the last beat; in_ready_o=0 for exactly one cycle.
- Accumulate: frame A = all words 0x0000_00F0, then frame B = 0x0000_000F with accum_i=1 -> every word 0x0000_00FF. A third frame of 0x1 with accum_i=0 -> every word 0x0000_0001.
- Overflow/ack: two frames with no ack -> overflow_o=1 and frame_cnt_o=2. Then ack_i -> new_o=0, overflow_o stays 1. Separately, ack_i in the commit cycle -> new_o=1, overflow_o=0.
- Framing: last on beat 5 -> frame_err_o=1, result_o unchanged, next 12-beat frame commits correctly. Then 12 beats with no last plus 3 beats ending in last -> frame_err_o=1, all 15 beats discarded, following frame commits.
- Backpressure and reset: in_valid_i toggling randomly gives the same result as the directed case. Assert rst_i after beat 6 -> all outputs zero, and a full frame after reset commits with frame_cnt_o=1.
- Clear and wrap: with CNT_WIDTH=2, commit 5 frames -> frame_cnt_o=1. Then clear_i -> result_o=0, all flags 0, frame_cnt_o=0, and in_ready_o=0 during the clear cycle.
